pipeline_exec_ctrl: RTL and testbench

PIPELINE_EXEC_CTRL -- requirements
Module: pipeline_exec_ctrl

---
 rtl/pipeline_exec_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller that gates the pipeline-stage enable in continuous or single-step mode.
// Optional cycle limit: define PIPELINE_CYCLE_LIMIT_EN to halt with o_timeout once MAX_CYCLES valid cycles have run.
module pipeline_exec_ctrl #(
  parameter int NB_CNT     = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_exec_mode,
  input  logic              i_step,
  input  logic              i_halt_wb,
  input  logic              i_abort,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_timeout,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_WAIT  = 3'd2,
    ST_STEP_PULSE = 3'd3,
    ST_HALTED     = 3'd4
  } state_t;

  state_t            state;
  logic              step_prev;
  logic [NB_CNT-1:0] cycle_count;
  logic              step_edge;
  logic              counting;
  logic              limit_hit;
  logic [NB_CNT-1:0] cnt_inc;

  assign step_edge = i_step & ~step_prev;
  assign counting  = (state == ST_RUN) || (state == ST_STEP_PULSE);
  assign cnt_inc   = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

`ifdef PIPELINE_CYCLE_LIMIT_EN
  logic timeout_q;
  assign limit_hit = counting && (cnt_inc == NB_CNT'(MAX_CYCLES));
  assign o_timeout = timeout_q;
`else
  logic unused_max_cycles;
  assign unused_max_cycles = (MAX_CYCLES != 0);
  assign limit_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // o_valid is a pure stage enable: downstream stages have no ready, so every
  // cycle it is high is consumed. It is high exactly in RUN and STEP_PULSE.
  assign o_valid       = counting;
  assign o_busy        = counting || (state == ST_STEP_WAIT);
  assign o_halted      = (state == ST_HALTED);
  assign o_state       = state;
  assign o_cycle_count = cycle_count;

  // The execution mode is latched implicitly by the branch taken at start:
  // RUN for continuous, the STEP_* pair for step-by-step.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      step_prev   <= 1'b0;
      cycle_count <= '0;
`ifdef PIPELINE_CYCLE_LIMIT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      step_prev <= i_step;
      if (counting) cycle_count <= cnt_inc;
      if (i_abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_HALTED: begin
            if (i_start) begin
              state       <= i_exec_mode ? ST_STEP_WAIT : ST_RUN;
              cycle_count <= '0;
`ifdef PIPELINE_CYCLE_LIMIT_EN
              timeout_q   <= 1'b0;
`endif
            end
          end
          ST_RUN: begin
            if (i_halt_wb || limit_hit) state <= ST_HALTED;
`ifdef PIPELINE_CYCLE_LIMIT_EN
            if (limit_hit) timeout_q <= 1'b1;
`endif
          end
          ST_STEP_WAIT: begin
            // Halt beats a coincident step edge so no stray pulse escapes.
            if (i_halt_wb)      state <= ST_HALTED;
            else if (step_edge) state <= ST_STEP_PULSE;
          end
          ST_STEP_PULSE: begin
            if (i_halt_wb || limit_hit) state <= ST_HALTED;
            else                        state <= ST_STEP_WAIT;
`ifdef PIPELINE_CYCLE_LIMIT_EN
            if (limit_hit) timeout_q <= 1'b1;
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: continuous run, stepping, halt/abort priority, reset, cycle limit.
module tb_pipeline_exec_ctrl;

  localparam int NB_CNT = 4;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_start = 1'b0;
  logic              i_exec_mode = 1'b0;
  logic              i_step = 1'b0;
  logic              i_halt_wb = 1'b0;
  logic              i_abort = 1'b0;
  logic              o_valid;
  logic              o_busy;
  logic              o_halted;
  logic              o_timeout;
  logic [2:0]        o_state;
  logic [NB_CNT-1:0] o_cycle_count;

  int errors = 0;
  int checks = 0;
  int seen;

  pipeline_exec_ctrl #(.NB_CNT(NB_CNT), .MAX_CYCLES(8)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_exec_mode   (i_exec_mode),
    .i_step        (i_step),
    .i_halt_wb     (i_halt_wb),
    .i_abort       (i_abort),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_halted      (o_halted),
    .o_timeout     (o_timeout),
    .o_state       (o_state),
    .o_cycle_count (o_cycle_count)
  );

  always #5 i_clock = ~i_clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    // Reset values
    chk("rst_state",   32'(o_state), 0);
    chk("rst_valid",   32'(o_valid), 0);
    chk("rst_busy",    32'(o_busy), 0);
    chk("rst_halted",  32'(o_halted), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_count",   32'(o_cycle_count), 0);
    i_reset = 1'b1;
    tick();
    chk("idle_hold", 32'(o_state), 0);

    // Continuous run, halt at write-back after 10 valid cycles
    i_start = 1'b1; i_exec_mode = 1'b0;
    tick();
    i_start = 1'b0;
    chk("run_state", 32'(o_state), 1);
    chk("run_busy",  32'(o_busy), 1);
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      seen += int'(o_valid);
      if (i == 10) i_halt_wb = 1'b1;
      tick();
    end
    i_halt_wb = 1'b0;
    chk("run_valid_cycles", seen, 10);
    chk("halt_state",  32'(o_state), 4);
    chk("halt_halted", 32'(o_halted), 1);
    chk("halt_valid",  32'(o_valid), 0);
    chk("halt_busy",   32'(o_busy), 0);
    chk("halt_count",  32'(o_cycle_count), 10);
    i_halt_wb = 1'b1;
    tick();
    tick();
    i_halt_wb = 1'b0;
    chk("halt_hold_state", 32'(o_state), 4);
    chk("halt_hold_count", 32'(o_cycle_count), 10);

    // Step mode: three edges, each level held five cycles
    i_start = 1'b1; i_exec_mode = 1'b1;
    tick();
    i_start = 1'b0; i_exec_mode = 1'b0;
    chk("step_start_state", 32'(o_state), 2);
    chk("step_start_count", 32'(o_cycle_count), 0);
    chk("step_start_valid", 32'(o_valid), 0);
    chk("step_start_busy",  32'(o_busy), 1);
    seen = 0;
    for (int s = 0; s < 3; s++) begin
      i_step = 1'b1;
      for (int k = 0; k < 5; k++) begin tick(); seen += int'(o_valid); end
      i_step = 1'b0;
      for (int k = 0; k < 3; k++) begin tick(); seen += int'(o_valid); end
    end
    chk("step_pulses", seen, 3);
    chk("step_count",  32'(o_cycle_count), 3);
    chk("step_state",  32'(o_state), 2);

    // Step edge and halt in the same cycle: halt wins, no pulse
    i_step = 1'b1; i_halt_wb = 1'b1;
    tick();
    i_halt_wb = 1'b0;
    chk("stephalt_state", 32'(o_state), 4);
    chk("stephalt_valid", 32'(o_valid), 0);
    tick();
    i_step = 1'b0;
    chk("stephalt_count", 32'(o_cycle_count), 3);
    chk("stephalt_hold",  32'(o_state), 4);

    // RUN for 5 cycles then abort together with start
    i_start = 1'b1; i_exec_mode = 1'b0;
    tick();
    i_start = 1'b0;
    chk("restart_count", 32'(o_cycle_count), 0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin i_abort = 1'b1; i_start = 1'b1; end
      tick();
    end
    i_abort = 1'b0; i_start = 1'b0;
    chk("abort_state", 32'(o_state), 0);
    chk("abort_busy",  32'(o_busy), 0);
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_count", 32'(o_cycle_count), 5);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_clear_count", 32'(o_cycle_count), 0);
    chk("start_clear_state", 32'(o_state), 1);

    // Reset mid-run after 7 cycles
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) i_reset = 1'b0;
      tick();
    end
    chk("midrst_state",  32'(o_state), 0);
    chk("midrst_valid",  32'(o_valid), 0);
    chk("midrst_busy",   32'(o_busy), 0);
    chk("midrst_halted", 32'(o_halted), 0);
    chk("midrst_count",  32'(o_cycle_count), 0);
    i_reset = 1'b1;

    // Halt and step edges ignored in IDLE
    i_halt_wb = 1'b1;
    tick();
    i_halt_wb = 1'b0;
    chk("idle_halt_ignored", 32'(o_state), 0);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("idle_step_ignored", 32'(o_state), 0);
    tick();

    // Long continuous run: limit or saturation
    i_start = 1'b1; i_exec_mode = 1'b0;
    tick();
    i_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen += int'(o_valid);
      tick();
    end
`ifdef PIPELINE_CYCLE_LIMIT_EN
    chk("limit_valid_cycles", seen, 8);
    chk("limit_timeout", 32'(o_timeout), 1);
    chk("limit_halted",  32'(o_halted), 1);
    chk("limit_count",   32'(o_cycle_count), 8);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("limit_timeout_clear", 32'(o_timeout), 0);
`else
    chk("nolimit_valid_cycles", seen, 20);
    chk("nolimit_still_valid",  32'(o_valid), 1);
    chk("nolimit_timeout",      32'(o_timeout), 0);
    chk("sat_count",            32'(o_cycle_count), 15);
`endif
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("final_abort_state", 32'(o_state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
